uart_tx_fifo_eng: RTL and testbench

Parametrised UART transmit engine with an internal transmit FIFO, table-driven baud selection and a selectable frame format: 7/8 data bits, optional odd/even parity, 1/2 stop bits. It sits between the processor output port (OUT_PORT/WRITE_0 strobe) and the TX pin. It lets software queue up to DEPTH characters without polling TXRDY per character.

---
 rtl/uart_tx_fifo_eng.sv | 247 ++++++++++++++++++++++++
 tb/tb_uart_tx_fifo_eng.sv | 293 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/uart_tx_fifo_eng.sv
// UART transmit engine with a DEPTH-entry FIFO, table-driven baud and 7/8 data, parity, 1/2 stop framing.
// Latency: write at cycle N -> EMPTY low at N+1, pop at N+1, start bit (TX=0, BUSY=1) at N+2.
// Backpressure: o_txrdy low while the FIFO is full; writes seen while full are dropped and set sticky o_overflow.
//
// Ports:
//   i_clk, i_reset        clock (rising edge) and synchronous active-high reset
//   i_baud[3:0]           baud code 0..10 = 300..460800, 11..15 = 921600
//   i_eight, i_parity_en, i_odd_n_even, i_two_stop   frame format, latched at frame start
//   i_out_port[7:0], i_write_0                        push data and one-cycle push strobe
//   i_send_break          (only with UART_TX_BREAK_EN) hold the line low while idle
//   o_txrdy, o_empty, o_level   registered FIFO status
//   o_busy, o_done, o_overflow, o_tx   frame status, end-of-frame pulse, dropped-write flag, serial line
//
// Optional feature macro: UART_TX_BREAK_EN (adds i_send_break and the BREAK/MARK states).

module uart_tx_fifo_eng #(
    parameter int CLK_FREQ = 100_000_000,
    parameter int DEPTH    = 8
) (
    input  logic                     i_clk,
    input  logic                     i_reset,
    input  logic [3:0]               i_baud,
    input  logic                     i_eight,
    input  logic                     i_parity_en,
    input  logic                     i_odd_n_even,
    input  logic                     i_two_stop,
    input  logic [7:0]               i_out_port,
    input  logic                     i_write_0,
`ifdef UART_TX_BREAK_EN
    input  logic                     i_send_break,
`endif
    output logic                     o_txrdy,
    output logic                     o_empty,
    output logic [$clog2(DEPTH):0]   o_level,
    output logic                     o_busy,
    output logic                     o_done,
    output logic                     o_overflow,
    output logic                     o_tx
);

    localparam int AW = $clog2(DEPTH);
    localparam int LW = AW + 1;

    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_START  = 3'd1,
        S_DATA   = 3'd2,
        S_PARITY = 3'd3,
        S_STOP   = 3'd4
`ifdef UART_TX_BREAK_EN
        ,
        S_BREAK  = 3'd5,
        S_MARK   = 3'd6
`endif
    } state_t;

    // Bit-time divisor for a baud code; every branch folds to a constant.
    function automatic logic [31:0] f_div(input logic [3:0] code);
        logic [31:0] d;
        case (code)
            4'd0:    d = 32'(CLK_FREQ / 300);
            4'd1:    d = 32'(CLK_FREQ / 1200);
            4'd2:    d = 32'(CLK_FREQ / 2400);
            4'd3:    d = 32'(CLK_FREQ / 4800);
            4'd4:    d = 32'(CLK_FREQ / 9600);
            4'd5:    d = 32'(CLK_FREQ / 19200);
            4'd6:    d = 32'(CLK_FREQ / 38400);
            4'd7:    d = 32'(CLK_FREQ / 57600);
            4'd8:    d = 32'(CLK_FREQ / 115200);
            4'd9:    d = 32'(CLK_FREQ / 230400);
            4'd10:   d = 32'(CLK_FREQ / 460800);
            default: d = 32'(CLK_FREQ / 921600);
        endcase
        return d;
    endfunction

    // ---------------------------------------------------------------- FIFO
    logic [7:0]    r_mem [DEPTH];
    logic [AW-1:0] r_wr_ptr;
    logic [AW-1:0] r_rd_ptr;
    logic [LW-1:0] r_level;
    logic          r_txrdy;
    logic          r_empty;
    logic          r_overflow;

    logic          w_push;
    logic          w_pop;
    logic [LW-1:0] w_level_nxt;
    logic [7:0]    w_head;
    logic [7:0]    w_head_m;

    // Full is taken from the registered status, so a write in the same cycle
    // as a pop from a full FIFO is still dropped.
    assign w_push      = i_write_0 && r_txrdy;
    assign w_level_nxt = r_level + LW'(w_push) - LW'(w_pop);
    assign w_head      = r_mem[r_rd_ptr];
    assign w_head_m    = i_eight ? w_head : {1'b0, w_head[6:0]};

    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            r_wr_ptr   <= '0;
            r_rd_ptr   <= '0;
            r_level    <= '0;
            r_txrdy    <= 1'b1;
            r_empty    <= 1'b1;
            r_overflow <= 1'b0;
        end else begin
            if (w_push) r_wr_ptr <= r_wr_ptr + AW'(1);
            if (w_pop)  r_rd_ptr <= r_rd_ptr + AW'(1);
            r_level <= w_level_nxt;
            r_txrdy <= (w_level_nxt != LW'(DEPTH));
            r_empty <= (w_level_nxt == '0);
            if (i_write_0 && !r_txrdy) r_overflow <= 1'b1;
        end
    end

    // Storage needs no reset: the cleared pointers make every entry invalid.
    always_ff @(posedge i_clk) begin
        if (w_push) r_mem[r_wr_ptr] <= i_out_port;
    end

    // ---------------------------------------------------------------- FSM
    state_t      r_state;
    state_t      w_state_nxt;
    logic [31:0] r_cnt;       // clocks elapsed in the current bit
    logic [31:0] r_bt;        // latched bit time
    logic [7:0]  r_shift;     // data bits, LSB goes out first
    logic [2:0]  r_bit_idx;
    logic [2:0]  r_last_idx;  // 6 for 7-bit frames, 7 for 8-bit frames
    logic        r_par_en;
    logic        r_par;
    logic        r_two_stop;
    logic        r_stop_idx;
    logic        w_bit_end;
    logic        w_tx;
    logic        w_done;

    assign w_bit_end = (r_cnt == r_bt - 32'd1);

    always_ff @(posedge i_clk) begin
        if (i_reset) r_state <= S_IDLE;
        else         r_state <= w_state_nxt;
    end

    always_comb begin
        w_state_nxt = r_state;
        w_pop       = 1'b0;
        w_done      = 1'b0;
        w_tx        = 1'b1;
        case (r_state)
            S_IDLE: begin
`ifdef UART_TX_BREAK_EN
                if (i_send_break) begin
                    w_state_nxt = S_BREAK;
                end else
`endif
                if (!r_empty) begin
                    w_state_nxt = S_START;
                    w_pop       = 1'b1;
                end
            end
            S_START: begin
                w_tx = 1'b0;
                if (w_bit_end) w_state_nxt = S_DATA;
            end
            S_DATA: begin
                w_tx = r_shift[0];
                if (w_bit_end && (r_bit_idx == r_last_idx))
                    w_state_nxt = r_par_en ? S_PARITY : S_STOP;
            end
            S_PARITY: begin
                w_tx = r_par;
                if (w_bit_end) w_state_nxt = S_STOP;
            end
            S_STOP: begin
                // The stop index reaches r_two_stop on the final stop bit.
                if (w_bit_end && (r_stop_idx == r_two_stop)) begin
                    w_state_nxt = S_IDLE;
                    w_done      = 1'b1;
                end
            end
`ifdef UART_TX_BREAK_EN
            S_BREAK: begin
                w_tx = 1'b0;
                if (!i_send_break) w_state_nxt = S_MARK;
            end
            S_MARK: begin
                if (w_bit_end) w_state_nxt = S_IDLE;
            end
`endif
            default: w_state_nxt = S_IDLE;
        endcase
    end

    // Bit timer, shift register and per-frame configuration.
    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            r_cnt      <= '0;
            r_bt       <= '0;
            r_shift    <= '0;
            r_bit_idx  <= '0;
            r_last_idx <= '0;
            r_par_en   <= 1'b0;
            r_par      <= 1'b0;
            r_two_stop <= 1'b0;
            r_stop_idx <= 1'b0;
        end else begin
            // Timer restarts on every bit boundary and every state change.
            if ((w_state_nxt != r_state) || w_bit_end) r_cnt <= '0;
            else                                        r_cnt <= r_cnt + 32'd1;

            if (w_pop) begin
                r_shift    <= w_head_m;
                r_bt       <= f_div(i_baud);
                r_last_idx <= i_eight ? 3'd7 : 3'd6;
                r_par_en   <= i_parity_en;
                r_par      <= (^w_head_m) ^ i_odd_n_even;
                r_two_stop <= i_two_stop;
                r_bit_idx  <= '0;
                r_stop_idx <= 1'b0;
            end
`ifdef UART_TX_BREAK_EN
            else if ((r_state == S_IDLE) && (w_state_nxt == S_BREAK)) begin
                // Mark time after a break uses the baud selected at break start.
                r_bt <= f_div(i_baud);
            end
`endif
            else if ((r_state == S_DATA) && w_bit_end) begin
                r_shift   <= {1'b0, r_shift[7:1]};
                r_bit_idx <= r_bit_idx + 3'd1;
            end else if ((r_state == S_STOP) && w_bit_end) begin
                r_stop_idx <= 1'b1;
            end
        end
    end

    // ---------------------------------------------------------------- outputs
    // o_tx and o_done decode registered state only; they never depend on inputs.
    assign o_txrdy    = r_txrdy;
    assign o_empty    = r_empty;
    assign o_level    = r_level;
    assign o_overflow = r_overflow;
    assign o_busy     = (r_state != S_IDLE);
    assign o_done     = w_done;
    assign o_tx       = w_tx;

endmodule

// File: tb/tb_uart_tx_fifo_eng.sv
module tb_uart_tx_fifo_eng;

    localparam int CLK_FREQ = 9_216_000;
    localparam int DEPTH    = 8;
    localparam int LW       = $clog2(DEPTH) + 1;

    logic          clk = 1'b0;
    logic          reset = 1'b1;
    logic [3:0]    baud = 4'd11;
    logic          eight = 1'b0, par_en = 1'b0, odd = 1'b0, two = 1'b0;
    logic [7:0]    dat = 8'h00;
    logic          wr = 1'b0;
`ifdef UART_TX_BREAK_EN
    logic          sb = 1'b0;
`endif
    logic          txrdy, empty, busy, done, ovf, tx;
    logic [LW-1:0] level;

    always #5 clk = ~clk;

    uart_tx_fifo_eng #(.CLK_FREQ(CLK_FREQ), .DEPTH(DEPTH)) dut (
        .i_clk(clk), .i_reset(reset), .i_baud(baud), .i_eight(eight),
        .i_parity_en(par_en), .i_odd_n_even(odd), .i_two_stop(two),
        .i_out_port(dat), .i_write_0(wr),
`ifdef UART_TX_BREAK_EN
        .i_send_break(sb),
`endif
        .o_txrdy(txrdy), .o_empty(empty), .o_level(level), .o_busy(busy),
        .o_done(done), .o_overflow(ovf), .o_tx(tx)
    );

    int n_tests = 0;
    int n_fail  = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // ------------------------------------------------ behavioural model
    // Queue of pending bytes plus the per-clock line waveform of the frame on air.
    int         rates [16] = '{300, 1200, 2400, 4800, 9600, 19200, 38400, 57600,
                               115200, 230400, 460800, 921600, 921600, 921600, 921600, 921600};
    logic [7:0] mq[$];
    logic       mw[$];
    logic       m_ovf = 1'b0;
    logic       m_chk = 1'b0;

    task automatic build_frame(input logic [7:0] d);
        int         bt, n;
        logic [7:0] m;
        logic       s[$];
        bt = CLK_FREQ / rates[baud];
        n  = eight ? 8 : 7;
        m  = eight ? d : {1'b0, d[6:0]};
        s.push_back(1'b0);
        for (int i = 0; i < n; i++) s.push_back(m[i]);
        if (par_en) s.push_back((^m) ^ odd);
        s.push_back(1'b1);
        if (two) s.push_back(1'b1);
        foreach (s[k]) for (int j = 0; j < bt; j++) mw.push_back(s[k]);
    endtask

    always @(negedge clk) begin
        logic [9:0] exp;
        logic       full;
        if (m_chk) begin
            exp = {(mw.size() > 0) ? mw[0] : 1'b1, mw.size() > 0, mw.size() == 1,
                   mq.size() < DEPTH, mq.size() == 0, m_ovf, LW'(mq.size())};
            check("cycle {tx,busy,done,txrdy,empty,ovf,level}",
                  {22'd0, tx, busy, done, txrdy, empty, ovf, level}, {22'd0, exp});
        end
        if (reset) begin
            mq.delete();
            mw.delete();
            m_ovf = 1'b0;
        end else begin
            full = (mq.size() >= DEPTH);
            if (mw.size() > 0)      void'(mw.pop_front());
            else if (mq.size() > 0) build_frame(mq.pop_front());
            if (wr) begin
                if (full) m_ovf = 1'b1;
                else      mq.push_back(dat);
            end
        end
    end

    // ------------------------------------------------ helpers
    logic ln [1200];
    int   dq[$];
    int   busy_cnt;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic capture(input int n);
        dq.delete();
        busy_cnt = 0;
        for (int i = 0; i < n; i++) begin
            ln[i] = tx;
            if (done) dq.push_back(i);
            if (busy) busy_cnt++;
            tick();
        end
    endtask

    // Line level in the middle of each of nb bit cells.
    function automatic logic [15:0] seq(input int nb, input int bt);
        logic [15:0] s = '0;
        for (int b = 0; b < nb; b++) s[b] = ln[b * bt + bt / 2];
        return s;
    endfunction

    task automatic wait_idle();
        int k = 0;
        while ((busy || !empty) && k < 5000) begin
            tick();
            k++;
        end
        check("wait_idle", {31'd0, busy || !empty}, 32'd0);
    endtask

    task automatic write1(input logic [7:0] d);
        dat = d;
        wr  = 1'b1;
        tick();
        wr  = 1'b0;
    endtask

    function automatic int first_done();
        return (dq.size() > 0) ? dq[0] : -1;
    endfunction

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish (limit 1000000 ns)");
        $fatal(1, "watchdog");
    end

    // ------------------------------------------------ directed tests
    initial begin
        int d1, d2, bad, lowc, markc;

        reset = 1'b1;
        repeat (3) tick();
        reset = 1'b0;
        check("reset tx", tx, 1);
        check("reset txrdy", txrdy, 1);
        check("reset empty", empty, 1);
        check("reset level", level, 0);
        check("reset busy", busy, 0);
        check("reset done", done, 0);
        check("reset ovf", ovf, 0);
        m_chk = 1'b1;

        // 7N1 0x55 at BT=10
        write1(8'h55);
        check("empty low N+1", empty, 0);
        check("tx still high N+1", tx, 1);
        tick();
        check("tx low N+2", tx, 0);
        check("busy N+2", busy, 1);
        capture(100);
        check("7N1 0x55 bits", seq(9, 10), 16'h01AA);
        check("7N1 done count", dq.size(), 1);
        check("7N1 frame end after fall", first_done() + 1, 90);

        // 8E2 0xA3, then 8O2
        wait_idle();
        eight = 1'b1; par_en = 1'b1; odd = 1'b0; two = 1'b1;
        write1(8'hA3);
        tick();
        capture(130);
        check("8E2 0xA3 bits", seq(12, 10), 16'h0D46);
        check("8E2 frame length", busy_cnt, 120);
        check("8E2 done pos", first_done(), 119);
        wait_idle();
        odd = 1'b1;
        write1(8'hA3);
        tick();
        capture(130);
        check("8O2 0xA3 bits", seq(12, 10), 16'h0F46);

        // 8O1 0x3C at baud 460800 (BT=20): 11 bits, parity 1
        wait_idle();
        baud = 4'd10; two = 1'b0;
        write1(8'h3C);
        tick();
        capture(240);
        check("8O1 BT20 frame length", busy_cnt, 220);
        check("8O1 BT20 parity bit", ln[190], 1);
        baud = 4'd11; eight = 1'b0; par_en = 1'b0; odd = 1'b0;

        // FIFO fill and overflow
        wait_idle();
        for (int i = 0; i < 10; i++) begin
            dat = 8'(i);
            wr  = 1'b1;
            if (i == 8) begin
                check("fill level before full", level, 7);
                check("fill txrdy before full", txrdy, 1);
            end
            if (i == 9) begin
                check("fill level full", level, 8);
                check("fill txrdy full", txrdy, 0);
            end
            tick();
        end
        wr = 1'b0;
        check("overflow set", ovf, 1);
        check("level after drop", level, 8);
        capture(9 * 91 + 60);
        check("frames sent", dq.size(), 9);
        bad = 0;
        for (int i = 1; i < dq.size(); i++) if (dq[i] - dq[i-1] != 91) bad++;
        check("back-to-back gaps", bad, 0);

        // Config latch: EIGHT 1->0 during first frame
        wait_idle();
        eight = 1'b1;
        dat = 8'h7F; wr = 1'b1;
        tick();
        tick();
        wr = 1'b0;
        dq.delete();
        for (int i = 0; i < 300; i++) begin
            if (i == 30) eight = 1'b0;
            ln[i] = tx;
            if (done) dq.push_back(i);
            tick();
        end
        d1 = (dq.size() > 0) ? dq[0] : -1;
        d2 = (dq.size() > 1) ? dq[1] : -1;
        check("latch frame1 bit7", ln[85], 0);
        check("latch frame1 end", d1, 99);
        check("latch frame2 stop at 8th slot", ln[186], 1);
        check("latch frame2 spacing", d2 - d1, 91);

        // Reset mid-frame with 3 queued
        wait_idle();
        for (int i = 0; i < 4; i++) begin
            dat = 8'h11 + 8'(i); wr = 1'b1;
            tick();
        end
        wr = 1'b0;
        repeat (25) tick();
        check("pre-reset level", level, 3);
        check("pre-reset ovf", ovf, 1);
        reset = 1'b1;
        tick();
        reset = 1'b0;
        check("midreset tx", tx, 1);
        check("midreset level", level, 0);
        check("midreset empty", empty, 1);
        check("midreset busy", busy, 0);
        check("midreset ovf", ovf, 0);
        capture(300);
        check("no frames after reset", busy_cnt, 0);

`ifdef UART_TX_BREAK_EN
        m_chk = 1'b0;
        sb = 1'b1;
        lowc = 0;
        for (int i = 0; i < 50; i++) begin
            tick();
            if (!tx && busy) lowc++;
        end
        sb = 1'b0;
        markc = 0;
        for (int i = 0; i < 20; i++) begin
            tick();
            if (tx && busy) markc++;
        end
        check("break low clocks", lowc, 50);
        check("break mark clocks", markc, 10);
        check("break back to idle", busy, 0);
        m_chk = 1'b1;
        tick();
`else
        lowc = 0; markc = 0;
`endif

        m_chk = 1'b0;
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
